dut_udiv_seq_22ns_10ns: RTL and testbench

Sequential unsigned restoring divider, the inverse of the 12x10->22 unsigned multiplier used in the dut datapath. Takes a 22-bit dividend and a 10-bit divisor, and returns a 12-bit quotient and a 10-bit remainder. Uses one quotient bit per cycle with an ap_start/ap_done block-level handshake. It recovers scale factors and averages in the LeNet5 post-processing path without a second DSP-heavy combinational divider.

---
 rtl/dut_udiv_seq_22ns_10ns_if.sv | 27 ++
 rtl/dut_udiv_seq_22ns_10ns.sv | 125 ++++++++++++
 tb/tb_dut_udiv_seq_22ns_10ns.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dut_udiv_seq_22ns_10ns_if.sv
// Block-level handshake and operand/result bundle for the sequential unsigned divider.
interface dut_udiv_seq_22ns_10ns_if #(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 10,
  parameter int QUOTIENT_WIDTH = DIVIDEND_WIDTH - DIVISOR_WIDTH
);
  logic                      ap_start;
  logic [DIVIDEND_WIDTH-1:0] din0;
  logic [DIVISOR_WIDTH-1:0]  din1;
  logic                      ap_idle;
  logic                      ap_done;
  logic                      ap_ready;
  logic [QUOTIENT_WIDTH-1:0] quot;
  logic [DIVISOR_WIDTH-1:0]  rem;
  logic                      div_zero;
  logic                      ovf;

  modport master (
    output ap_start, din0, din1,
    input  ap_idle, ap_done, ap_ready, quot, rem, div_zero, ovf
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_idle, ap_done, ap_ready, quot, rem, div_zero, ovf
  );
endinterface

// File: rtl/dut_udiv_seq_22ns_10ns.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with ap_start/ap_done
// handshake, divide-by-zero and quotient-overflow flags; all outputs are registered.
module dut_udiv_seq_22ns_10ns #(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 10,
  parameter int QUOTIENT_WIDTH = DIVIDEND_WIDTH - DIVISOR_WIDTH
) (
  input logic                     ap_clk,
  input logic                     ap_rst_n,
  dut_udiv_seq_22ns_10ns_if.slave bus
);
  localparam int CNT_W = $clog2(QUOTIENT_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [QUOTIENT_WIDTH-1:0] r_dvd;
  logic [DIVISOR_WIDTH-1:0]  r_prem;
  logic [DIVISOR_WIDTH-1:0]  r_lo;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [QUOTIENT_WIDTH-2:0] r_q;
  logic                      r_dz;
  logic                      r_ovf;
  logic [QUOTIENT_WIDTH-1:0] r_quot;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic                      r_div_zero;
  logic                      r_ovf_out;

  logic [DIVISOR_WIDTH:0]    w_shift;
  logic                      w_qbit;
  logic [DIVISOR_WIDTH-1:0]  w_prem_nx;
  logic [QUOTIENT_WIDTH-1:0] w_quot_nx;
  logic                      w_last;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.ap_start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit and keep the difference only if non-negative.
  always_comb begin
    w_shift   = {r_prem, r_dvd[QUOTIENT_WIDTH-1]};
    w_qbit    = (w_shift >= {1'b0, r_divisor});
    w_prem_nx = w_qbit ? DIVISOR_WIDTH'(w_shift - {1'b0, r_divisor})
                       : w_shift[DIVISOR_WIDTH-1:0];
    w_quot_nx = {r_q, w_qbit};
    w_last    = (r_cnt == CNT_W'(QUOTIENT_WIDTH - 1));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_prem     <= '0;
      r_lo       <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      r_ovf_out  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.ap_start) begin
            // Upper dividend slice preloads the partial remainder, so only the low
            // QUOTIENT_WIDTH bits remain to be shifted in; it is below the divisor unless ovf.
            r_cnt     <= '0;
            r_dvd     <= bus.din0[QUOTIENT_WIDTH-1:0];
            r_prem    <= bus.din0[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
            r_lo      <= bus.din0[DIVISOR_WIDTH-1:0];
            r_divisor <= bus.din1;
            r_q       <= '0;
            r_dz      <= (bus.din1 == '0);
            r_ovf     <= (bus.din1 != '0) &&
                         (bus.din0[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH] >= bus.din1);
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_dvd  <= {r_dvd[QUOTIENT_WIDTH-2:0], 1'b0};
          r_prem <= w_prem_nx;
          r_q    <= w_quot_nx[QUOTIENT_WIDTH-2:0];
          if (w_last) begin
            r_div_zero <= r_dz;
            r_ovf_out  <= r_ovf && !r_dz;
            if (r_dz) begin
              r_quot <= '1;
              r_rem  <= r_lo;
            end else if (r_ovf) begin
              r_quot <= '1;
              r_rem  <= '0;
            end else begin
              r_quot <= w_quot_nx;
              r_rem  <= w_prem_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ap_idle  = (r_state == S_IDLE);
  assign bus.ap_done  = (r_state == S_DONE);
  assign bus.ap_ready = (r_state == S_DONE);
  assign bus.quot     = r_quot;
  assign bus.rem      = r_rem;
  assign bus.div_zero = r_div_zero;
  assign bus.ovf      = r_ovf_out;
endmodule

// File: tb/tb_dut_udiv_seq_22ns_10ns.sv
// Scoreboard bench for the sequential divider: accepted requests push arithmetic-model results,
// a negedge monitor checks handshake timing, results, holding behaviour and reset.
module tb_dut_udiv_seq_22ns_10ns;
  logic clk;
  logic rst_n;

  dut_udiv_seq_22ns_10ns_if bus ();

  dut_udiv_seq_22ns_10ns #(
    .DIVIDEND_WIDTH (22),
    .DIVISOR_WIDTH  (10),
    .QUOTIENT_WIDTH (12)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [11:0] quot;
    logic [9:0]  rem;
    logic        dz;
    logic        ovf;
    logic [21:0] a;
    logic [9:0]  b;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_last;
  exp_t        e_cur;
  int unsigned cyc = 0;
  int unsigned m_next_ok = 0;
  int unsigned m_idle_from = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic        exp_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t zero_exp();
    exp_t z;
    z.quot = '0; z.rem = '0; z.dz = 1'b0; z.ovf = 1'b0; z.a = '0; z.b = '0; z.due = 0;
    return z;
  endfunction

  // Arithmetic reference: plain integer division with the error overrides.
  function automatic exp_t model(input logic [21:0] a, input logic [9:0] b, input int unsigned due);
    exp_t        e;
    int unsigned q;
    e = zero_exp();
    e.a = a; e.b = b; e.due = due;
    if (b == 0) begin
      e.dz = 1'b1; e.quot = 12'hFFF; e.rem = a[9:0];
    end else begin
      q = 32'(a) / 32'(b);
      if (q >= 4096) begin
        e.ovf = 1'b1; e.quot = 12'hFFF; e.rem = '0;
      end else begin
        e.quot = 12'(q);
        e.rem  = 10'(32'(a) % 32'(b));
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Request acceptance model: a start is taken only once the previous operation has fully retired.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_next_ok   <= 0;
      m_idle_from <= 0;
    end else if (bus.ap_start && (cyc + 1 >= m_next_ok)) begin
      sb.push_back(model(bus.din0, bus.din1, cyc + 13));
      m_next_ok   <= cyc + 15;
      m_idle_from <= cyc + 14;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_last <= zero_exp();
    end else begin
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      chk("ap_idle", 32'(bus.ap_idle), 32'(cyc >= m_idle_from));
      chk("ap_done", 32'(bus.ap_done), 32'(exp_done));
      chk("ap_ready", 32'(bus.ap_ready), 32'(exp_done));
      if (exp_done) begin
        e_cur = sb.pop_front();
        chk("quot", 32'(bus.quot), 32'(e_cur.quot));
        chk("rem", 32'(bus.rem), 32'(e_cur.rem));
        chk("div_zero", 32'(bus.div_zero), 32'(e_cur.dz));
        chk("ovf", 32'(bus.ovf), 32'(e_cur.ovf));
        if (!e_cur.dz && !e_cur.ovf) begin
          chk("mul_xcheck", 32'(bus.quot) * 32'(e_cur.b) + 32'(bus.rem), 32'(e_cur.a));
          chk("rem_lt_div", 32'(bus.rem < e_cur.b), 32'd1);
        end
        m_last <= e_cur;
      end else begin
        chk("hold_quot", 32'(bus.quot), 32'(m_last.quot));
        chk("hold_rem", 32'(bus.rem), 32'(m_last.rem));
        chk("hold_dz", 32'(bus.div_zero), 32'(m_last.dz));
        chk("hold_ovf", 32'(bus.ovf), 32'(m_last.ovf));
      end
    end
  end

  task automatic issue(input logic [21:0] a, input logic [9:0] b);
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.din0     = a;
    bus.din1     = b;
    @(negedge clk);
    bus.ap_start = 1'b0;
    bus.din0     = 22'($urandom);
    bus.din1     = 10'($urandom);
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [21:0] a;
    logic [9:0]  b;
    logic [21:0] dir_a[9];
    logic [9:0]  dir_b[9];
    dir_a = '{22'd1000, 22'h3FFFFF, 22'd4189185, 22'h12345, 22'd0,
              22'h3FFFFF, 22'd4095, 22'd4096, 22'd4190207};
    dir_b = '{10'd7, 10'h3FF, 10'd1023, 10'd0, 10'd1,
              10'd1, 10'd1, 10'd1, 10'd1023};

    rst_n        = 1'b0;
    bus.ap_start = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    issue(22'd1000, 10'd7);
    wait_cyc(13);

    // Abort mid-calculation: outputs must clear and no completion may follow.
    issue(22'd1000, 10'd7);
    wait_cyc(4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_idle", 32'(bus.ap_idle), 32'd1);
    chk("rst_done", 32'(bus.ap_done), 32'd0);
    chk("rst_ready", 32'(bus.ap_ready), 32'd0);
    chk("rst_quot", 32'(bus.quot), 32'd0);
    chk("rst_rem", 32'(bus.rem), 32'd0);
    chk("rst_flags", {30'd0, bus.div_zero, bus.ovf}, 32'd0);
    wait_cyc(2);
    #2 rst_n = 1'b1;
    wait_cyc(20);

    for (int i = 0; i < 9; i++) begin
      issue(dir_a[i], dir_b[i]);
      wait_cyc(13);
    end

    // Start held high with operands churning every cycle.
    @(negedge clk);
    bus.ap_start = 1'b1;
    for (int i = 0; i < 14 * 6; i++) begin
      bus.din0 = 22'($urandom);
      bus.din1 = (i % 17 == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      @(negedge clk);
    end
    bus.ap_start = 1'b0;
    wait_cyc(14);

    for (int i = 0; i < 1500; i++) begin
      if (i % 10 == 0) begin
        a = 22'($urandom);
        b = 10'($urandom_range(0, 1023));
      end else begin
        b = 10'($urandom_range(1, 1023));
        a = 22'($urandom % (32'(b) << 12));
      end
      issue(a, b);
      wait_cyc(12);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
